// File: rtl/uart_word_rx.sv
// UART receive front end: 8N1 bytes from the rx pin, paired high byte first into 16-bit words,
// delivered through a one-entry valid/ready register. Define UART_WORD_RX_PARITY_EN for 8E1 frames.
`timescale 1ns/1ps
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        rx,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_WORD_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic              rx_meta;
  logic              rxs;
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              wait_high_q, wait_high_d;
`ifdef UART_WORD_RX_PARITY_EN
  logic              par_err_q, par_err_d;
`endif
  logic              stop_ok;
  logic              byte_good;
  logic              byte_bad;

  logic [7:0]        hi_byte;
  logic              hi_pending;
  logic              word_load;
  logic              load_ok;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;
`ifdef UART_WORD_RX_PARITY_EN
    par_err_d   = par_err_q;
    stop_ok     = rxs && !par_err_q;
`else
    stop_ok     = rxs;
`endif
    byte_good   = 1'b0;
    byte_bad    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // After a bad stop bit the line must return high before a new start is honoured.
        if (rxs) begin
          wait_high_d = 1'b0;
        end else if (!wait_high_q) begin
          baud_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_q == BAUD_MID) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_WORD_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

`ifdef UART_WORD_RX_PARITY_EN
      S_PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          par_err_d = rxs ^ (^shift_q);
          state_d   = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
`ifdef UART_WORD_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
          if (stop_ok) begin
            byte_good = 1'b1;
          end else begin
            byte_bad    = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else if (ce) begin
      rx_meta     <= rx;
      rxs         <= rx_meta;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
`ifdef UART_WORD_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // The second good byte of a pair completes a word; it loads if the slot is free or draining now.
  assign word_load = byte_good && hi_pending;
  assign load_ok   = !word_valid || word_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_byte    <= '0;
      hi_pending <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (ce) begin
      frame_err <= byte_bad;
      overrun   <= 1'b0;

      if (byte_good) begin
        hi_pending <= !hi_pending;
        if (!hi_pending) begin
          hi_byte <= shift_q;
        end
      end else if (byte_bad) begin
        hi_pending <= 1'b0;
      end

      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (word_load) begin
        if (load_ok) begin
          word_out   <= {hi_byte, shift_q};
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != S_IDLE) || hi_pending;

endmodule
